// File: rtl/ws2812_strip_driver.sv
// WS2812 strip driver: serialises NUM_LEDS pixel words (GRB/GRBW) onto a single-wire line.
// Optional macro WS2812_BRIGHTNESS_EN adds a brightness input that scales each channel on intake.
module ws2812_strip_driver #(
   parameter int unsigned CLK_FREQ_KHZ   = 10000,
   parameter int unsigned NUM_LEDS       = 8,
   parameter int unsigned BITS_PER_PIXEL = 24,
   parameter int unsigned T0H_NS         = 400,
   parameter int unsigned T1H_NS         = 800,
   parameter int unsigned BIT_NS         = 1250,
   parameter int unsigned RESET_US       = 50
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      frame_start,
   input  logic [BITS_PER_PIXEL-1:0] pix_data,
   input  logic                      pix_valid,
`ifdef WS2812_BRIGHTNESS_EN
   input  logic [7:0]                brightness,
`endif
   output logic                      pix_ready,
   output logic                      busy,
   output logic                      underrun,
   output logic                      data_output
);

   function automatic int unsigned cyc_of(input longint unsigned num, input longint unsigned den);
      longint unsigned v;
      v = num / den;
      return (v == 64'd0) ? 32'd1 : 32'(v);
   endfunction

   localparam int unsigned T0H_CYC   = cyc_of(64'(CLK_FREQ_KHZ) * 64'(T0H_NS), 64'd1000000);
   localparam int unsigned T1H_CYC   = cyc_of(64'(CLK_FREQ_KHZ) * 64'(T1H_NS), 64'd1000000);
   localparam int unsigned BIT_CYC   = cyc_of(64'(CLK_FREQ_KHZ) * 64'(BIT_NS), 64'd1000000);
   localparam int unsigned RESET_CYC = cyc_of(64'(CLK_FREQ_KHZ) * 64'(RESET_US), 64'd1000);
   localparam int unsigned CNT_MAX   = (BIT_CYC > RESET_CYC) ? BIT_CYC : RESET_CYC;
   localparam int unsigned CW        = $clog2(CNT_MAX + 1);
   localparam int unsigned BW        = $clog2(BITS_PER_PIXEL);
   localparam int unsigned PW        = $clog2(NUM_LEDS + 1);

   if (BITS_PER_PIXEL != 24 && BITS_PER_PIXEL != 32) begin : g_bpp_check
      $error("BITS_PER_PIXEL must be 24 or 32");
   end
   if (T1H_CYC >= BIT_CYC) begin : g_timing_check
      $error("T1H cycle count must be shorter than the bit period");
   end
   if (NUM_LEDS < 1 || NUM_LEDS > 4095) begin : g_leds_check
      $error("NUM_LEDS must be in 1..4095");
   end

   typedef enum logic [2:0] {
      S_IDLE,
      S_PREFETCH,
      S_BIT_HIGH,
      S_BIT_LOW,
      S_LATCH
   } state_t;

   state_t                    state_q, state_d;
   logic [CW-1:0]             cyc_q, cyc_d;
   logic [BW-1:0]             bit_q, bit_d;
   logic [BITS_PER_PIXEL-1:0] shift_q, shift_d;
   logic [BITS_PER_PIXEL-1:0] hold_q, hold_d;
   logic                      hold_full_q, hold_full_d;
   logic [PW-1:0]             accepted_q, accepted_d;
   logic [PW-1:0]             sent_q, sent_d;
   logic                      underrun_q, underrun_d;
   logic [BITS_PER_PIXEL-1:0] pix_in;
   logic [CW-1:0]             high_last;
   logic                      reload;
   logic                      xfer;
   logic                      active;

`ifdef WS2812_BRIGHTNESS_EN
   function automatic logic [BITS_PER_PIXEL-1:0] scale_px(input logic [BITS_PER_PIXEL-1:0] px,
                                                         input logic [7:0] b);
      logic [BITS_PER_PIXEL-1:0] r;
      logic [15:0]               prod;
      r = '0;
      for (int unsigned i = 0; i < BITS_PER_PIXEL / 8; i++) begin
         prod = {8'd0, px[i*8 +: 8]} * ({8'd0, b} + 16'd1);
         r[i*8 +: 8] = 8'(prod >> 8);
      end
      return r;
   endfunction

   assign pix_in = scale_px(pix_data, brightness);
`else
   assign pix_in = pix_data;
`endif

   assign busy        = (state_q != S_IDLE);
   assign data_output = (state_q == S_BIT_HIGH);
   assign underrun    = underrun_q;
   assign high_last   = shift_q[BITS_PER_PIXEL-1] ? CW'(T1H_CYC - 1) : CW'(T0H_CYC - 1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         cyc_q       <= '0;
         bit_q       <= '0;
         shift_q     <= '0;
         hold_q      <= '0;
         hold_full_q <= 1'b0;
         accepted_q  <= '0;
         sent_q      <= '0;
         underrun_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         cyc_q       <= cyc_d;
         bit_q       <= bit_d;
         shift_q     <= shift_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
         accepted_q  <= accepted_d;
         sent_q      <= sent_d;
         underrun_q  <= underrun_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cyc_d       = cyc_q;
      bit_d       = bit_q;
      shift_d     = shift_q;
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      accepted_d  = accepted_q;
      sent_d      = sent_q;
      underrun_d  = 1'b0;
      reload      = 1'b0;

      active    = (state_q == S_PREFETCH) || (state_q == S_BIT_HIGH) || (state_q == S_BIT_LOW);
      pix_ready = !hold_full_q && (accepted_q < PW'(NUM_LEDS)) && active;
      xfer      = pix_valid && pix_ready;

      case (state_q)
         S_IDLE: begin
            if (frame_start) begin
               state_d    = S_PREFETCH;
               accepted_d = '0;
               sent_d     = '0;
               cyc_d      = '0;
               bit_d      = '0;
            end
         end
         S_PREFETCH: begin
            if (hold_full_q) begin
               reload  = 1'b1;
               state_d = S_BIT_HIGH;
               cyc_d   = '0;
               bit_d   = '0;
            end
         end
         S_BIT_HIGH: begin
            cyc_d = cyc_q + 1'b1;
            if (cyc_q == high_last) begin
               state_d = S_BIT_LOW;
            end
         end
         S_BIT_LOW: begin
            if (cyc_q == CW'(BIT_CYC - 1)) begin
               cyc_d = '0;
               if (bit_q != BW'(BITS_PER_PIXEL - 1)) begin
                  bit_d   = bit_q + 1'b1;
                  shift_d = shift_q << 1;
                  state_d = S_BIT_HIGH;
               end else begin
                  // Pixel boundary: reload straight into BIT_HIGH so the line stays gap-free
                  bit_d  = '0;
                  sent_d = sent_q + 1'b1;
                  if (sent_q == PW'(NUM_LEDS - 1)) begin
                     state_d = S_LATCH;
                  end else if (hold_full_q) begin
                     reload  = 1'b1;
                     state_d = S_BIT_HIGH;
                  end else begin
                     underrun_d = 1'b1;
                     state_d    = S_LATCH;
                  end
               end
            end else begin
               cyc_d = cyc_q + 1'b1;
            end
         end
         S_LATCH: begin
            if (cyc_q == CW'(RESET_CYC - 1)) begin
               state_d = S_IDLE;
               cyc_d   = '0;
            end else begin
               cyc_d = cyc_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Consume before fill so a same-cycle reload and transfer leave the new pixel held
      if (reload) begin
         shift_d     = hold_q;
         hold_full_d = 1'b0;
      end
      if (xfer) begin
         hold_d      = pix_in;
         hold_full_d = 1'b1;
         accepted_d  = accepted_q + 1'b1;
      end
   end

endmodule

// File: tb/tb_ws2812_strip_driver.sv
// Directed bench for ws2812_strip_driver: three instances (1 LED, 3 LEDs, 32-bit pixels)
// decoded from the serial line by pulse width.
`timescale 1ns/1ps
module tb_ws2812_strip_driver;

   logic clk = 1'b0;
   always #50 clk = ~clk;

   logic rst_n;
   logic clr;
   int   checks;
   int   failures;

   logic        fs_a, pv_a, rdy_a, busy_a, ur_a, dout_a;
   logic [23:0] pd_a;
   logic        fs_b, pv_b, rdy_b, busy_b, ur_b, dout_b;
   logic [23:0] pd_b;
   logic        fs_c, pv_c, rdy_c, busy_c, ur_c, dout_c;
   logic [31:0] pd_c;
   int          acc_a, acc_b, acc_c;
`ifdef WS2812_BRIGHTNESS_EN
   logic [7:0]  bright_a;
   logic [7:0]  bright_bc;
`endif

   ws2812_strip_driver #(.NUM_LEDS(1), .BITS_PER_PIXEL(24)) u_a (
      .clk(clk), .rst_n(rst_n), .frame_start(fs_a), .pix_data(pd_a), .pix_valid(pv_a),
`ifdef WS2812_BRIGHTNESS_EN
      .brightness(bright_a),
`endif
      .pix_ready(rdy_a), .busy(busy_a), .underrun(ur_a), .data_output(dout_a)
   );

   ws2812_strip_driver #(.NUM_LEDS(3), .BITS_PER_PIXEL(24)) u_b (
      .clk(clk), .rst_n(rst_n), .frame_start(fs_b), .pix_data(pd_b), .pix_valid(pv_b),
`ifdef WS2812_BRIGHTNESS_EN
      .brightness(bright_bc),
`endif
      .pix_ready(rdy_b), .busy(busy_b), .underrun(ur_b), .data_output(dout_b)
   );

   ws2812_strip_driver #(.NUM_LEDS(1), .BITS_PER_PIXEL(32)) u_c (
      .clk(clk), .rst_n(rst_n), .frame_start(fs_c), .pix_data(pd_c), .pix_valid(pv_c),
`ifdef WS2812_BRIGHTNESS_EN
      .brightness(bright_bc),
`endif
      .pix_ready(rdy_c), .busy(busy_c), .underrun(ur_c), .data_output(dout_c)
   );

   // Handshake counters; instance b walks a three-pixel table as pixels are accepted
   always @(posedge clk) begin
      if (clr) begin
         acc_a <= 0;
         acc_b <= 0;
         acc_c <= 0;
      end else begin
         if (pv_a && rdy_a) acc_a <= acc_a + 1;
         if (pv_b && rdy_b) acc_b <= acc_b + 1;
         if (pv_c && rdy_c) acc_c <= acc_c + 1;
      end
   end

   assign pd_b = (acc_b == 0) ? 24'hA5C3F0 : (acc_b == 1) ? 24'h0F1E2D : 24'h800001;

   function automatic logic line_of(input int d);
      case (d)
         0:       return dout_a;
         1:       return dout_b;
         default: return dout_c;
      endcase
   endfunction

   function automatic logic busy_of(input int d);
      case (d)
         0:       return busy_a;
         1:       return busy_b;
         default: return busy_c;
      endcase
   endfunction

   function automatic logic ur_of(input int d);
      case (d)
         0:       return ur_a;
         1:       return ur_b;
         default: return ur_c;
      endcase
   endfunction

   task automatic pulse_start(input int d);
      case (d)
         0:       fs_a = 1'b1;
         1:       fs_b = 1'b1;
         default: fs_c = 1'b1;
      endcase
      @(negedge clk);
      fs_a = 1'b0;
      fs_b = 1'b0;
      fs_c = 1'b0;
   endtask

   task automatic clear_counts();
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
   endtask

   // Decodes nbits by high width (8 -> 1, 4 -> 0); any bit not exactly 12 cycles counts as an error.
   task automatic capture(input int d, input int nbits, output logic [95:0] bits,
                          output int errs, output int cycles, output bit tmo);
      int hi, lo, w;
      bits = '0; errs = 0; cycles = 0; tmo = 1'b0; w = 0;
      while (line_of(d) !== 1'b1 && w < 3000) begin
         @(negedge clk);
         w++;
      end
      if (w >= 3000) begin
         tmo = 1'b1;
         return;
      end
      for (int b = 0; b < nbits; b++) begin
         hi = 0;
         lo = 0;
         while (line_of(d) === 1'b1 && hi < 20) begin hi++; @(negedge clk); end
         while (line_of(d) === 1'b0 && hi + lo < 12) begin lo++; @(negedge clk); end
         if (hi == 8)      bits = {bits[94:0], 1'b1};
         else if (hi == 4) bits = {bits[94:0], 1'b0};
         else              errs++;
         if (hi + lo != 12) errs++;
         cycles += hi + lo;
      end
   endtask

   task automatic measure_latch(input int d, output int n, output int hi_seen, output int ur_pulses);
      n = 0; hi_seen = 0; ur_pulses = 0;
      while (busy_of(d) === 1'b1 && n < 2000) begin
         if (line_of(d) !== 1'b0) hi_seen++;
         if (ur_of(d) === 1'b1) ur_pulses++;
         n++;
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      clear_counts();
      repeat (2) @(negedge clk);
      checks++; if ({dout_a, busy_a, rdy_a, ur_a} !== 4'b0000) begin failures++;
         $display("FAIL reset_a got=%b exp=0000", {dout_a, busy_a, rdy_a, ur_a}); end
      checks++; if ({dout_b, busy_b, rdy_b, ur_b, dout_c, busy_c} !== 6'b0) begin failures++;
         $display("FAIL reset_bc got=%b exp=000000", {dout_b, busy_b, rdy_b, ur_b, dout_c, busy_c}); end
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if ({dout_a, busy_a, rdy_a, busy_b, rdy_b} !== 5'b0) begin failures++;
         $display("FAIL idle_after_reset got=%b exp=00000", {dout_a, busy_a, rdy_a, busy_b, rdy_b}); end
   endtask

   task automatic test_single_pixel();
      logic [95:0] bits;
      int errs, cyc, n, hs, up;
      bit tmo;
      pd_a = 24'hFF0080;
      pv_a = 1'b1;
      clear_counts();
      pulse_start(0);
      checks++; if (busy_a !== 1'b1) begin failures++;
         $display("FAIL single_busy_rise got=%b exp=1", busy_a); end
      pulse_start(0);
      capture(0, 24, bits, errs, cyc, tmo);
      checks++; if (tmo) begin failures++; $display("FAIL single_timeout got=timeout exp=first_bit"); end
      checks++; if (bits[23:0] !== 24'hFF0080) begin failures++;
         $display("FAIL single_bits got=%h exp=ff0080", bits[23:0]); end
      checks++; if (errs !== 0 || cyc !== 288) begin failures++;
         $display("FAIL single_timing got errs=%0d cycles=%0d exp errs=0 cycles=288", errs, cyc); end
      measure_latch(0, n, hs, up);
      checks++; if (n !== 500 || hs !== 0 || up !== 0) begin failures++;
         $display("FAIL single_latch got=%0d/%0d/%0d exp=500/0/0", n, hs, up); end
      checks++; if (acc_a !== 1) begin failures++;
         $display("FAIL single_accepts got=%0d exp=1", acc_a); end
      repeat (4) @(negedge clk);
      checks++; if ({busy_a, dout_a, rdy_a} !== 3'b000) begin failures++;
         $display("FAIL single_idle got=%b exp=000", {busy_a, dout_a, rdy_a}); end
      pv_a = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [95:0] bits;
      int errs, cyc, n, hs, up;
      bit tmo;
      pv_b = 1'b1;
      clear_counts();
      pulse_start(1);
      capture(1, 72, bits, errs, cyc, tmo);
      checks++; if (tmo) begin failures++; $display("FAIL b2b_timeout got=timeout exp=first_bit"); end
      checks++; if (bits[71:0] !== 72'hA5C3F0_0F1E2D_800001) begin failures++;
         $display("FAIL b2b_bits got=%h exp=a5c3f00f1e2d800001", bits[71:0]); end
      checks++; if (errs !== 0 || cyc !== 864) begin failures++;
         $display("FAIL b2b_timing got errs=%0d cycles=%0d exp errs=0 cycles=864", errs, cyc); end
      measure_latch(1, n, hs, up);
      checks++; if (n !== 500 || hs !== 0 || up !== 0) begin failures++;
         $display("FAIL b2b_latch got=%0d/%0d/%0d exp=500/0/0", n, hs, up); end
      checks++; if (acc_b !== 3) begin failures++;
         $display("FAIL b2b_accepts got=%0d exp=3", acc_b); end
      pv_b = 1'b0;
   endtask

   task automatic test_underrun();
      logic [95:0] bits;
      int errs, cyc, n, hs, up, w;
      bit tmo;
      pv_b = 1'b1;
      clear_counts();
      pulse_start(1);
      w = 0;
      while (acc_b != 1 && w < 100) begin @(negedge clk); w++; end
      pv_b = 1'b0;
      capture(1, 24, bits, errs, cyc, tmo);
      checks++; if (tmo || bits[23:0] !== 24'hA5C3F0 || errs !== 0) begin failures++;
         $display("FAIL underrun_first_pixel got=%h errs=%0d exp=a5c3f0 errs=0", bits[23:0], errs); end
      checks++; if (ur_b !== 1'b1 || dout_b !== 1'b0) begin failures++;
         $display("FAIL underrun_pulse got ur=%b line=%b exp ur=1 line=0", ur_b, dout_b); end
      pv_b = 1'b1;
      measure_latch(1, n, hs, up);
      checks++; if (n !== 500 || hs !== 0 || up !== 1) begin failures++;
         $display("FAIL underrun_latch got=%0d/%0d/%0d exp=500/0/1", n, hs, up); end
      repeat (3) @(negedge clk);
      checks++; if (acc_b !== 1 || busy_b !== 1'b0) begin failures++;
         $display("FAIL underrun_no_request got acc=%0d busy=%b exp acc=1 busy=0", acc_b, busy_b); end
      pv_b = 1'b0;
   endtask

   task automatic test_reset_mid_frame();
      logic [95:0] bits;
      int errs, cyc, w;
      bit tmo;
      pv_b = 1'b1;
      clear_counts();
      pulse_start(1);
      w = 0;
      while (dout_b !== 1'b1 && w < 100) begin @(negedge clk); w++; end
      repeat (338) @(negedge clk);
      checks++; if (dout_b !== 1'b1) begin failures++;
         $display("FAIL midreset_pulse_before got=%b exp=1", dout_b); end
      rst_n = 1'b0;
      #1;
      checks++; if ({dout_b, busy_b, rdy_b, ur_b} !== 4'b0000) begin failures++;
         $display("FAIL midreset_immediate got=%b exp=0000", {dout_b, busy_b, rdy_b, ur_b}); end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      checks++; if ({dout_b, busy_b} !== 2'b00) begin failures++;
         $display("FAIL midreset_no_resume got=%b exp=00", {dout_b, busy_b}); end
      clear_counts();
      pulse_start(1);
      capture(1, 72, bits, errs, cyc, tmo);
      checks++; if (tmo || bits[71:0] !== 72'hA5C3F0_0F1E2D_800001 || errs !== 0) begin failures++;
         $display("FAIL midreset_restart got=%h errs=%0d exp=a5c3f00f1e2d800001 errs=0", bits[71:0], errs); end
      pv_b = 1'b0;
      w = 0;
      while (busy_b === 1'b1 && w < 1000) begin @(negedge clk); w++; end
   endtask

   task automatic test_grbw();
      logic [95:0] bits;
      int errs, cyc, n, hs, up;
      bit tmo;
      pd_c = 32'h80000001;
      pv_c = 1'b1;
      clear_counts();
      pulse_start(2);
      capture(2, 32, bits, errs, cyc, tmo);
      checks++; if (tmo || bits[31:0] !== 32'h80000001) begin failures++;
         $display("FAIL grbw_bits got=%h exp=80000001", bits[31:0]); end
      checks++; if (errs !== 0 || cyc !== 384) begin failures++;
         $display("FAIL grbw_timing got errs=%0d cycles=%0d exp errs=0 cycles=384", errs, cyc); end
      measure_latch(2, n, hs, up);
      checks++; if (n !== 500 || acc_c !== 1) begin failures++;
         $display("FAIL grbw_latch got latch=%0d acc=%0d exp latch=500 acc=1", n, acc_c); end
      pv_c = 1'b0;
   endtask

`ifdef WS2812_BRIGHTNESS_EN
   task automatic test_brightness();
      logic [95:0] bits;
      int errs, cyc, n, hs, up;
      bit tmo;
      bright_a = 8'd127;
      pd_a = 24'hFF8002;
      pv_a = 1'b1;
      clear_counts();
      pulse_start(0);
      capture(0, 24, bits, errs, cyc, tmo);
      checks++; if (tmo || bits[23:0] !== 24'h7F4001 || errs !== 0) begin failures++;
         $display("FAIL brightness_bits got=%h errs=%0d exp=7f4001 errs=0", bits[23:0], errs); end
      measure_latch(0, n, hs, up);
      pv_a = 1'b0;
      bright_a = 8'd255;
   endtask
`endif

   initial begin
      checks = 0;
      failures = 0;
      rst_n = 1'b0;
      clr = 1'b1;
      fs_a = 1'b0; fs_b = 1'b0; fs_c = 1'b0;
      pv_a = 1'b0; pv_b = 1'b0; pv_c = 1'b0;
      pd_a = '0; pd_c = '0;
`ifdef WS2812_BRIGHTNESS_EN
      bright_a = 8'd255;
      bright_bc = 8'd255;
`endif
      @(negedge clk);
      test_reset();
      test_single_pixel();
      test_back_to_back();
      test_underrun();
      test_reset_mid_frame();
      test_grbw();
`ifdef WS2812_BRIGHTNESS_EN
      test_brightness();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #5ms;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
